// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit:
// funct3 codes, FSM state encoding and the byte-enable helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STORE     = 3'd1,
        S_LOAD_REQ  = 3'd2,
        S_LOAD_WAIT = 3'd3,
        S_RESP      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    // Lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] be_from_addr(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load result formatting: selects the addressed byte/half of a RAM word and
// sign- or zero-extends it. Ports: word (RAM data), off (addr[1:0]), funct3, data.
module lsu_load_extract
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = word >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    data = word;
            F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment unit between the core memory stage and a byte-lane RAM
// with 1-cycle registered reads. Ports: clk/clk_en/rst, core request
// (i_req_*, o_req_ready), response (o_resp_*), RAM read and write ports.
module lsu_mem_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RAM_AW = 12
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    output logic            o_resp_err,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_read_req,
    output logic [XLEN-1:0] o_read_addr,
    input  logic [XLEN-1:0] i_read_data,
    output logic            o_write_enable,
    output logic [3:0]      o_byte_enable,
    output logic [XLEN-1:0] o_write_addr,
    output logic [XLEN-1:0] o_write_data
);

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      f3_q;
    logic [2:0]      f3_d;
    logic [1:0]      off_q;
    logic [1:0]      off_d;

    logic            ready_d;
    logic            resp_valid_d;
    logic            resp_err_d;
    logic [XLEN-1:0] resp_rdata_d;
    logic            read_req_d;
    logic [XLEN-1:0] read_addr_d;
    logic            write_enable_d;
    logic [3:0]      byte_enable_d;
    logic [XLEN-1:0] write_addr_d;
    logic [XLEN-1:0] write_data_d;

    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic            out_of_range;
    logic [XLEN-1:0] word_idx;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] load_data;

    assign accept = (state_q == S_IDLE) && i_req_valid;

    // Error decode on the raw request; it only matters at accept.
    always_comb begin
        if (i_req_we) begin
            illegal = (i_req_funct3 >= 3'b011);
        end else begin
            illegal = (i_req_funct3 == 3'b011) ||
                      (i_req_funct3 == 3'b110) ||
                      (i_req_funct3 == 3'b111);
        end
        misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        out_of_range = |i_req_addr[XLEN-1:RAM_AW+2];
    end

    assign word_idx = {{(XLEN-RAM_AW){1'b0}}, i_req_addr[RAM_AW+1:2]};

    always_comb begin
        case (i_req_funct3[1:0])
            2'b00:   store_data = {4{i_req_wdata[7:0]}};
            2'b01:   store_data = {2{i_req_wdata[15:0]}};
            default: store_data = i_req_wdata;
        endcase
    end

    lsu_load_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .word  (i_read_data),
        .off   (off_q),
        .funct3(f3_q),
        .data  (load_data)
    );

    // Next-state and next-output logic; every output is registered, so the
    // values computed here appear in the cycle after the edge.
    always_comb begin
        state_d        = state_q;
        f3_d           = f3_q;
        off_d          = off_q;
        ready_d        = 1'b0;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_rdata_d   = '0;
        read_req_d     = 1'b0;
        read_addr_d    = '0;
        write_enable_d = 1'b0;
        byte_enable_d  = 4'b0000;
        write_addr_d   = '0;
        write_data_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    f3_d    = i_req_funct3;
                    off_d   = i_req_addr[1:0];
                    if (illegal || misaligned || out_of_range) begin
                        state_d      = S_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (i_req_we) begin
                        state_d        = S_STORE;
                        resp_valid_d   = 1'b1;
                        write_enable_d = 1'b1;
                        byte_enable_d  = be_from_addr(i_req_funct3, i_req_addr[1:0]);
                        write_addr_d   = word_idx;
                        write_data_d   = store_data;
                    end else begin
                        state_d     = S_LOAD_REQ;
                        read_req_d  = 1'b1;
                        read_addr_d = word_idx;
                    end
                end
            end
            S_LOAD_REQ: begin
                state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            S_STORE, S_RESP, S_ERR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            o_req_ready    <= 1'b1;
            o_resp_valid   <= 1'b0;
            o_resp_err     <= 1'b0;
            o_resp_rdata   <= '0;
            o_read_req     <= 1'b0;
            o_read_addr    <= '0;
            o_write_enable <= 1'b0;
            o_byte_enable  <= 4'b0000;
            o_write_addr   <= '0;
            o_write_data   <= '0;
        end else if (clk_en) begin
            state_q        <= state_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            o_req_ready    <= ready_d;
            o_resp_valid   <= resp_valid_d;
            o_resp_err     <= resp_err_d;
            o_resp_rdata   <= resp_rdata_d;
            o_read_req     <= read_req_d;
            o_read_addr    <= read_addr_d;
            o_write_enable <= write_enable_d;
            o_byte_enable  <= byte_enable_d;
            o_write_addr   <= write_addr_d;
            o_write_data   <= write_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_align.sv
// Self-checking bench for lsu_mem_align: directed vector table plus
// hand-written clock-enable freeze and mid-operation reset sequences.
module tb_lsu_mem_align;

    localparam int XLEN   = 32;
    localparam int RAM_AW = 12;

    logic            clk = 1'b0;
    logic            clk_en;
    logic            rst;
    logic            i_req_valid;
    logic            o_req_ready;
    logic            i_req_we;
    logic [2:0]      i_req_funct3;
    logic [XLEN-1:0] i_req_addr;
    logic [XLEN-1:0] i_req_wdata;
    logic            o_resp_valid;
    logic            o_resp_err;
    logic [XLEN-1:0] o_resp_rdata;
    logic            o_read_req;
    logic [XLEN-1:0] o_read_addr;
    logic [XLEN-1:0] i_read_data;
    logic            o_write_enable;
    logic [3:0]      o_byte_enable;
    logic [XLEN-1:0] o_write_addr;
    logic [XLEN-1:0] o_write_data;

    always #5 clk = ~clk;

    lsu_mem_align #(
        .XLEN  (XLEN),
        .RAM_AW(RAM_AW)
    ) dut (
        .clk           (clk),
        .clk_en        (clk_en),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_funct3  (i_req_funct3),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .o_resp_valid  (o_resp_valid),
        .o_resp_err    (o_resp_err),
        .o_resp_rdata  (o_resp_rdata),
        .o_read_req    (o_read_req),
        .o_read_addr   (o_read_addr),
        .i_read_data   (i_read_data),
        .o_write_enable(o_write_enable),
        .o_byte_enable (o_byte_enable),
        .o_write_addr  (o_write_addr),
        .o_write_data  (o_write_data)
    );

    // Byte-lane RAM with registered read, gated by the same clock enable.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    logic [31:0] rd_q = 32'h0;
    assign i_read_data = rd_q;

    always @(posedge clk) begin
        if (clk_en) begin
            if (o_write_enable) begin
                for (int b = 0; b < 4; b++) begin
                    if (o_byte_enable[b])
                        mem[o_write_addr[RAM_AW-1:0]][8*b +: 8] <= o_write_data[8*b +: 8];
                end
            end
            if (o_read_req)
                rd_q <= mem[o_read_addr[RAM_AW-1:0]];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] widx;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
    } vec_t;

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got 0, expected 1");
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
    endtask

    task automatic scramble();
        i_req_valid  = 1'b0;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b111;
        i_req_addr   = 32'hFFFF_FFFF;
        i_req_wdata  = 32'h0BAD_0BAD;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ready"}, {31'b0, o_req_ready}, 32'd1);
        chk({tag, ".resp_valid"}, {31'b0, o_resp_valid}, 32'd0);
        chk({tag, ".resp_err"}, {31'b0, o_resp_err}, 32'd0);
        chk({tag, ".rdata"}, o_resp_rdata, 32'd0);
        chk({tag, ".read_req"}, {31'b0, o_read_req}, 32'd0);
        chk({tag, ".read_addr"}, o_read_addr, 32'd0);
        chk({tag, ".we"}, {31'b0, o_write_enable}, 32'd0);
        chk({tag, ".be"}, {28'b0, o_byte_enable}, 32'd0);
        chk({tag, ".waddr"}, o_write_addr, 32'd0);
        chk({tag, ".wdata"}, o_write_data, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready();
        drive(v.we, v.f3, v.addr, v.wdata);
        @(negedge clk);
        scramble();
        chk({v.name, ".ready_busy"}, {31'b0, o_req_ready}, 32'd0);
        if (v.err || v.we) begin
            chk({v.name, ".resp_valid"}, {31'b0, o_resp_valid}, 32'd1);
            chk({v.name, ".resp_err"}, {31'b0, o_resp_err}, {31'b0, v.err});
            chk({v.name, ".rdata"}, o_resp_rdata, 32'd0);
            chk({v.name, ".read_req"}, {31'b0, o_read_req}, 32'd0);
            chk({v.name, ".we"}, {31'b0, o_write_enable}, {31'b0, v.we & ~v.err});
            if (!v.err) begin
                chk({v.name, ".be"}, {28'b0, o_byte_enable}, {28'b0, v.be});
                chk({v.name, ".waddr"}, o_write_addr, v.widx);
                chk({v.name, ".wdata"}, o_write_data, v.wd);
            end
        end else begin
            chk({v.name, ".read_req"}, {31'b0, o_read_req}, 32'd1);
            chk({v.name, ".read_addr"}, o_read_addr, v.widx);
            chk({v.name, ".early_valid1"}, {31'b0, o_resp_valid}, 32'd0);
            @(negedge clk);
            chk({v.name, ".read_req_drop"}, {31'b0, o_read_req}, 32'd0);
            chk({v.name, ".early_valid2"}, {31'b0, o_resp_valid}, 32'd0);
            @(negedge clk);
            chk({v.name, ".resp_valid"}, {31'b0, o_resp_valid}, 32'd1);
            chk({v.name, ".resp_err"}, {31'b0, o_resp_err}, 32'd0);
            chk({v.name, ".rdata"}, o_resp_rdata, v.rdata);
        end
        @(negedge clk);
        chk({v.name, ".pulse_end"}, {31'b0, o_resp_valid}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
        clk_en = 1'b1;
        rst    = 1'b1;
        scramble();
        i_req_valid = 1'b0;

        // name, we, f3, addr, wdata, err, widx, be, wd, rdata
        vecs.push_back('{"sw_10",   1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 32'd4,     4'hF, 32'hDEADBEEF, 0});
        vecs.push_back('{"sb_13",   1, 3'b000, 32'h13,   32'h000000A5, 0, 32'd4,     4'h8, 32'hA5A5A5A5, 0});
        vecs.push_back('{"lb_13",   0, 3'b000, 32'h13,   0,            0, 32'd4,     4'h0, 0, 32'hFFFFFFA5});
        vecs.push_back('{"lbu_13",  0, 3'b100, 32'h13,   0,            0, 32'd4,     4'h0, 0, 32'h000000A5});
        vecs.push_back('{"lw_10",   0, 3'b010, 32'h10,   0,            0, 32'd4,     4'h0, 0, 32'hA5ADBEEF});
        vecs.push_back('{"sw_0",    1, 3'b010, 32'h0,    32'h80001234, 0, 32'd0,     4'hF, 32'h80001234, 0});
        vecs.push_back('{"lh_2",    0, 3'b001, 32'h2,    0,            0, 32'd0,     4'h0, 0, 32'hFFFF8000});
        vecs.push_back('{"lhu_2",   0, 3'b101, 32'h2,    0,            0, 32'd0,     4'h0, 0, 32'h00008000});
        vecs.push_back('{"lh_0",    0, 3'b001, 32'h0,    0,            0, 32'd0,     4'h0, 0, 32'h00001234});
        vecs.push_back('{"sh_2",    1, 3'b001, 32'h2,    32'h1111BEEF, 0, 32'd0,     4'hC, 32'hBEEFBEEF, 0});
        vecs.push_back('{"sb_1",    1, 3'b000, 32'h1,    32'h12345677, 0, 32'd0,     4'h2, 32'h77777777, 0});
        vecs.push_back('{"lw_0",    0, 3'b010, 32'h0,    0,            0, 32'd0,     4'h0, 0, 32'hBEEF7734});
        vecs.push_back('{"lb_1",    0, 3'b000, 32'h1,    0,            0, 32'd0,     4'h0, 0, 32'h00000077});
        vecs.push_back('{"sw_top",  1, 3'b010, 32'h3FFC, 32'h12345678, 0, 32'hFFF,   4'hF, 32'h12345678, 0});
        vecs.push_back('{"lw_top",  0, 3'b010, 32'h3FFC, 0,            0, 32'hFFF,   4'h0, 0, 32'h12345678});
        vecs.push_back('{"lw_mis",  0, 3'b010, 32'h6,    0,            1, 0,         4'h0, 0, 0});
        vecs.push_back('{"sh_mis",  1, 3'b001, 32'h1,    32'hFFFF,     1, 0,         4'h0, 0, 0});
        vecs.push_back('{"lw_oor",  0, 3'b010, 32'h4000, 0,            1, 0,         4'h0, 0, 0});
        vecs.push_back('{"ld_f011", 0, 3'b011, 32'h0,    0,            1, 0,         4'h0, 0, 0});
        vecs.push_back('{"st_f100", 1, 3'b100, 32'h0,    32'h1,        1, 0,         4'h0, 0, 0});
        vecs.push_back('{"lw_0_ok", 0, 3'b010, 32'h0,    0,            0, 32'd0,     4'h0, 0, 32'hBEEF7734});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Clock enable low while a store strobe is high: strobes must hold.
        wait_ready();
        drive(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        scramble();
        clk_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("frz_st.we_hold", {31'b0, o_write_enable}, 32'd1);
            chk("frz_st.valid_hold", {31'b0, o_resp_valid}, 32'd1);
            chk("frz_st.waddr_hold", o_write_addr, 32'd16);
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("frz_st.we_drop", {31'b0, o_write_enable}, 32'd0);
        chk("frz_st.ready", {31'b0, o_req_ready}, 32'd1);
        run_vec('{"lw_40", 0, 3'b010, 32'h40, 0, 0, 32'd16, 4'h0, 0, 32'hCAFEF00D});

        // Clock enable low for 3 cycles during LOAD_WAIT; request inputs
        // are toggled while busy and must be ignored.
        wait_ready();
        drive(1'b0, 3'b000, 32'h3FFF, 32'h0);
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h10, 32'h0);
        chk("frz_ld.read_req", {31'b0, o_read_req}, 32'd1);
        @(negedge clk);
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frz_ld.no_resp", {31'b0, o_resp_valid}, 32'd0);
            chk("frz_ld.no_ready", {31'b0, o_req_ready}, 32'd0);
        end
        clk_en = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("frz_ld.resp_valid", {31'b0, o_resp_valid}, 32'd1);
        chk("frz_ld.rdata", o_resp_rdata, 32'h00000012);
        @(negedge clk);
        chk("frz_ld.ready", {31'b0, o_req_ready}, 32'd1);
        chk("frz_ld.no_write", {31'b0, o_write_enable}, 32'd0);

        // Reset while in STORE.
        wait_ready();
        drive(1'b1, 3'b010, 32'h20, 32'h55555555);
        @(negedge clk);
        scramble();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_store");

        // Reset while in LOAD_REQ: no response may follow.
        wait_ready();
        drive(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        scramble();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_load");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_load.no_resp", {31'b0, o_resp_valid}, 32'd0);
        end
        run_vec('{"lw_after_rst", 0, 3'b010, 32'h10, 0, 0, 32'd4, 4'h0, 0, 32'hA5ADBEEF});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
